// File: rtl/ifu_pkg.sv
// Shared types and widths for the instruction-fetch unit.
package ifu_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 30;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    RESP
  } fetch_state_t;
endpackage

// File: rtl/ifu_fetch_sat_counter.sv
// Saturating up-counter used for the fetch performance counters.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count = count_q;
endmodule

// File: rtl/ifu_fetch.sv
// Fetch controller: one-cycle icache lookup, memory refill on miss, flush and
// hit/miss counters. The icache itself lives beside this block in the SoC.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter bit          IDLE_ON_FLUSH = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             fetch_ready,
  input  logic             flush,
  output logic [PC_W-1:0]  ic_addr,
  output logic             ic_req,
  input  logic             ic_hit,
  input  logic [XLEN-1:0]  ic_rdata,
  output logic             ic_wen,
  output logic [XLEN-1:0]  ic_wdata,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_addr,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_resp_data,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [PC_W-1:0]  inst_pc,
  input  logic             inst_ready,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            kill_q, kill_d;
  logic            fetch_ready_q, ic_req_q, mem_req_valid_q, inst_valid_q;
  logic            hit_inc, miss_inc, fill;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    data_d   = data_q;
    kill_d   = kill_q;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_valid && !flush) begin
          pc_d    = fetch_pc;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (ic_hit) begin
          hit_inc = 1'b1;
          data_d  = ic_rdata;
          state_d = flush ? IDLE : RESP;
        end else begin
          miss_inc = 1'b1;
          state_d  = flush ? IDLE : MEM_REQ;
        end
      end
      MEM_REQ: begin
        // An accepted request must be drained, so a coincident flush only marks it killed.
        if (mem_req_ready) begin
          kill_d  = flush;
          state_d = MEM_WAIT;
        end else if (flush) begin
          state_d = IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem_resp_valid) begin
          if (kill_q || flush) begin
            fill    = IDLE_ON_FLUSH;
            kill_d  = 1'b0;
            state_d = IDLE;
          end else begin
            fill    = 1'b1;
            data_d  = mem_resp_data;
            state_d = RESP;
          end
        end else if (flush) begin
          kill_d = 1'b1;
        end
      end
      RESP: begin
        if (inst_ready || flush) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are flopped from the next state so they match state_q exactly.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      pc_q            <= '0;
      data_q          <= '0;
      kill_q          <= 1'b0;
      fetch_ready_q   <= 1'b1;
      ic_req_q        <= 1'b0;
      mem_req_valid_q <= 1'b0;
      inst_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      data_q          <= data_d;
      kill_q          <= kill_d;
      fetch_ready_q   <= (state_d == IDLE);
      ic_req_q        <= (state_d == LOOKUP);
      mem_req_valid_q <= (state_d == MEM_REQ);
      inst_valid_q    <= (state_d == RESP);
    end
  end

  // A fill seen while reset is asserted is abandoned.
  assign ic_wen        = fill && reset;
  assign ic_wdata      = ic_wen ? mem_resp_data : '0;
  assign ic_addr       = pc_q;
  assign ic_req        = ic_req_q;
  assign fetch_ready   = fetch_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = {pc_q, 2'b00};
  assign inst_valid    = inst_valid_q;
  assign inst          = data_q;
  assign inst_pc       = pc_q;

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (hit_inc),
    .count (hit_cnt)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (miss_inc),
    .count (miss_cnt)
  );
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small direct-mapped icache model.
module tb_ifu_fetch;
  logic        clock;
  logic        reset;
  logic        fetch_valid;
  logic [29:0] fetch_pc;
  logic        fetch_ready;
  logic        flush;
  logic [29:0] ic_addr;
  logic        ic_req;
  logic        ic_hit;
  logic [31:0] ic_rdata;
  logic        ic_wen;
  logic [31:0] ic_wdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [29:0] inst_pc;
  logic        inst_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  logic        s_fetch_ready, s_ic_req, s_ic_wen, s_mem_req_valid, s_inst_valid;
  logic [29:0] s_ic_addr, s_inst_pc;
  logic [31:0] s_ic_wdata, s_mem_addr, s_inst;
  logic [1:0]  s_hit_cnt, s_miss_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  int wen_cnt  = 0;
  int mreq_cnt = 0;
  int w0, m0;

  ifu_fetch dut (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .flush(flush), .ic_addr(ic_addr), .ic_req(ic_req),
    .ic_hit(ic_hit), .ic_rdata(ic_rdata), .ic_wen(ic_wen), .ic_wdata(ic_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  ifu_fetch #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_ready(s_fetch_ready), .flush(flush), .ic_addr(s_ic_addr), .ic_req(s_ic_req),
    .ic_hit(ic_hit), .ic_rdata(ic_rdata), .ic_wen(s_ic_wen), .ic_wdata(s_ic_wdata),
    .mem_req_valid(s_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(s_mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .inst_valid(s_inst_valid), .inst(s_inst), .inst_pc(s_inst_pc), .inst_ready(inst_ready),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  // Direct-mapped icache model, 16 entries indexed by word address [3:0].
  logic [15:0] c_vld = '0;
  logic [29:0] c_tag [16];
  logic [31:0] c_dat [16];

  always_comb begin
    ic_hit   = c_vld[ic_addr[3:0]] && (c_tag[ic_addr[3:0]] == ic_addr);
    ic_rdata = c_dat[ic_addr[3:0]];
  end

  always @(posedge clock) begin
    if (ic_wen) begin
      c_vld[ic_addr[3:0]] <= 1'b1;
      c_tag[ic_addr[3:0]] <= ic_addr;
      c_dat[ic_addr[3:0]] <= ic_wdata;
    end
    if (ic_wen) wen_cnt <= wen_cnt + 1;
    if (mem_req_valid) mreq_cnt <= mreq_cnt + 1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Starts and ends at a negedge in IDLE; address must already be cached.
  task automatic do_hit(input logic [29:0] pc, input logic [31:0] data);
    fetch_valid = 1'b1;
    fetch_pc    = pc;
    inst_ready  = 1'b1;
    @(negedge clock);
    fetch_valid = 1'b0;
    check("hit_lookup", ic_hit, 1);
    @(negedge clock);
    check("hit_valid", inst_valid, 1);
    check("hit_inst", inst, data);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; fetch_valid = 1'b0; fetch_pc = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_fetch_ready", fetch_ready, 1);
    check("rst_ic_req", ic_req, 0);
    check("rst_mem_req", mem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    reset = 1'b1;

    // Cold miss at 0x10
    fetch_valid = 1'b1; fetch_pc = 30'h10; mem_req_ready = 1'b1;
    @(negedge clock);
    fetch_valid = 1'b0;
    check("cold_ic_req", ic_req, 1);
    check("cold_ic_addr", ic_addr, 30'h10);
    check("cold_ic_hit", ic_hit, 0);
    @(negedge clock);
    check("cold_mem_req", mem_req_valid, 1);
    check("cold_mem_addr", mem_addr, 32'h40);
    @(negedge clock);
    check("cold_mem_req_drop", mem_req_valid, 0);
    @(negedge clock);
    @(negedge clock);
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0013_0313;
    #1;
    check("cold_ic_wen", ic_wen, 1);
    check("cold_ic_wdata", ic_wdata, 32'h0013_0313);
    check("cold_ic_req_low", ic_req, 0);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    check("cold_inst_valid", inst_valid, 1);
    check("cold_inst", inst, 32'h0013_0313);
    check("cold_inst_pc", inst_pc, 30'h10);
    check("cold_miss_cnt", miss_cnt, 1);
    check("cold_wen_cnt", wen_cnt, 1);
    inst_ready = 1'b1;
    @(negedge clock);
    check("cold_idle", fetch_ready, 1);
    check("cold_inst_drop", inst_valid, 0);

    // Warm hit with decode backpressure
    m0 = mreq_cnt;
    fetch_valid = 1'b1; fetch_pc = 30'h10; inst_ready = 1'b0;
    @(negedge clock);
    fetch_valid = 1'b0;
    check("warm_not_yet", inst_valid, 0);
    check("warm_ic_hit", ic_hit, 1);
    @(negedge clock);
    check("warm_hit_cnt", hit_cnt, 1);
    check("warm_no_mem", mreq_cnt, m0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", inst_valid, 1);
      check("bp_inst", inst, 32'h0013_0313);
      check("bp_inst_pc", inst_pc, 30'h10);
      check("bp_fetch_ready", fetch_ready, 0);
      if (i < 4) @(negedge clock);
    end
    inst_ready = 1'b1;
    @(negedge clock);
    check("bp_idle", fetch_ready, 1);
    check("bp_inst_drop", inst_valid, 0);

    // Flush during MEM_WAIT at 0x21: fill completes, instruction discarded
    w0 = wen_cnt;
    fetch_valid = 1'b1; fetch_pc = 30'h21; inst_ready = 1'b0; mem_req_ready = 1'b1;
    @(negedge clock);
    fetch_valid = 1'b0;
    @(negedge clock);
    check("fw_mem_req", mem_req_valid, 1);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    #1;
    check("fw_ic_wen", ic_wen, 1);
    @(negedge clock);
    mem_resp_valid = 1'b0;
    check("fw_no_inst", inst_valid, 0);
    check("fw_idle", fetch_ready, 1);
    check("fw_wen_cnt", wen_cnt, w0 + 1);
    do_hit(30'h21, 32'hDEAD_BEEF);
    check("fw_hit_cnt", hit_cnt, 2);

    // Flush during MEM_REQ at 0x33 with memory stalled
    mem_req_ready = 1'b0;
    fetch_valid = 1'b1; fetch_pc = 30'h33;
    @(negedge clock);
    fetch_valid = 1'b0;
    @(negedge clock);
    check("fr_mem_req", mem_req_valid, 1);
    check("fr_mem_addr", mem_addr, 32'hCC);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    w0 = wen_cnt;
    check("fr_mem_req_drop", mem_req_valid, 0);
    check("fr_idle", fetch_ready, 1);
    check("fr_miss_cnt", miss_cnt, 3);
    @(negedge clock);
    @(negedge clock);
    check("fr_no_fill", wen_cnt, w0);

    // Reset in MEM_WAIT at 0x44 with a coincident response
    mem_req_ready = 1'b1;
    fetch_valid = 1'b1; fetch_pc = 30'h44;
    @(negedge clock);
    fetch_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    w0 = wen_cnt;
    reset = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
    #1;
    check("rw_no_wen", ic_wen, 0);
    @(negedge clock);
    check("rw_fetch_ready", fetch_ready, 1);
    check("rw_ic_req", ic_req, 0);
    check("rw_ic_wen", ic_wen, 0);
    check("rw_ic_wdata", ic_wdata, 0);
    check("rw_mem_req", mem_req_valid, 0);
    check("rw_mem_addr", mem_addr, 0);
    check("rw_inst_valid", inst_valid, 0);
    check("rw_inst", inst, 0);
    check("rw_inst_pc", inst_pc, 0);
    check("rw_hit_cnt", hit_cnt, 0);
    check("rw_miss_cnt", miss_cnt, 0);
    reset = 1'b1; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    @(negedge clock);
    check("rw_no_fill", wen_cnt, w0);

    // Saturation: 2-bit counter sticks at 3 after 5 hits
    do_hit(30'h10, 32'h0013_0313);
    do_hit(30'h10, 32'h0013_0313);
    check("sat_two", s_hit_cnt, 2);
    do_hit(30'h10, 32'h0013_0313);
    do_hit(30'h10, 32'h0013_0313);
    do_hit(30'h10, 32'h0013_0313);
    check("sat_hit_cnt", s_hit_cnt, 3);
    check("wide_hit_cnt", hit_cnt, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
